sm3_cf_iter: RTL and testbench



---
 rtl/sm3_pkg.sv | 70 +++++++
 rtl/sm3_wexp.sv | 62 ++++++
 rtl/sm3_cf_iter.sv | 107 ++++++++++
 tb/tb_sm3_cf_iter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sm3_pkg.sv
// SM3 constants, state encoding and round/message-expansion helper functions.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a. Macro SM3_CF_UNROLL2_EN selects two rounds per cycle (RPC).
package sm3_pkg;

    localparam logic [255:0] SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0]  T_LO   = 32'h79cc4519;
    localparam logic [31:0]  T_HI   = 32'h7a879d8a;
    localparam int           ROUNDS = 64;

`ifdef SM3_CF_UNROLL2_EN
    localparam int RPC = 2;  // rounds per RUN cycle
`else
    localparam int RPC = 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    // Working registers A..H; A sits in the top word, matching iv/hashValue order.
    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } regs_t;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] P0(input logic [31:0] x);
        return x ^ rol32(x, 5'd9) ^ rol32(x, 5'd17);
    endfunction

    function automatic logic [31:0] P1(input logic [31:0] x);
        return x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23);
    endfunction

    function automatic logic [31:0] FF(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic [5:0] j);
        return (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
    endfunction

    function automatic logic [31:0] GG(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic [5:0] j);
        return (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (~x & z));
    endfunction

    // One SM3 round j; w0/w4 are the current window words W[0] and W[4].
    function automatic regs_t sm3_round(input regs_t s, input logic [5:0] j,
                                        input logic [31:0] w0, input logic [31:0] w4);
        logic [31:0] tj, a12, ss1, ss2, tt1, tt2;
        regs_t r;
        tj  = (j < 6'd16) ? T_LO : T_HI;
        a12 = rol32(s.a, 5'd12);
        ss1 = rol32(a12 + s.e + rol32(tj, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        tt1 = FF(s.a, s.b, s.c, j) + s.d + ss2 + (w0 ^ w4);
        tt2 = GG(s.e, s.f, s.g, j) + s.h + ss1 + w0;
        r.a = tt1;
        r.b = s.a;
        r.c = rol32(s.b, 5'd9);
        r.d = s.c;
        r.e = P0(tt2);
        r.f = s.e;
        r.g = rol32(s.f, 5'd19);
        r.h = s.g;
        return r;
    endfunction

endpackage

// File: rtl/sm3_wexp.sv
// SM3 message expansion: 16x32 sliding window, loaded from a block, shifted RPC words per cycle.
// Latency: load/shift take effect on the next rising edge; outputs are registered window words.
// Backpressure: none; the owner gates load/shift. SM3_CF_UNROLL2_EN generates two words per shift.
module sm3_wexp
    import sm3_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      shift,
    input  logic [511:0]              blk,
    output logic [RPC-1:0][31:0]      w_lo,   // W[k],   k < RPC
    output logic [RPC-1:0][31:0]      w_hi    // W[k+4], k < RPC
);

    logic [15:0][31:0] win;
    logic [15:0][31:0] win_nxt;
    logic [15:0][31:0] win_ld;
    logic [31:0]       w16;
`ifdef SM3_CF_UNROLL2_EN
    logic [31:0]       w17;
`endif

    // Block unpack (W0 is the most significant word) and next-window generation.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            win_ld[i] = blk[32*(15-i) +: 32];
        end
        w16 = P1(win[0] ^ win[7] ^ rol32(win[13], 5'd15)) ^ rol32(win[3], 5'd7) ^ win[10];
        win_nxt = win;
`ifdef SM3_CF_UNROLL2_EN
        // W17 only needs words already in the window, so both are generated in parallel.
        w17 = P1(win[1] ^ win[8] ^ rol32(win[14], 5'd15)) ^ rol32(win[4], 5'd7) ^ win[11];
        for (int i = 0; i < 14; i++) begin
            win_nxt[i] = win[i+2];
        end
        win_nxt[14] = w16;
        win_nxt[15] = w17;
`else
        for (int i = 0; i < 15; i++) begin
            win_nxt[i] = win[i+1];
        end
        win_nxt[15] = w16;
`endif
        for (int k = 0; k < RPC; k++) begin
            w_lo[k] = win[k];
            w_hi[k] = win[k+4];
        end
    end

    // Window register: load wins over shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            win <= '0;
        end else if (load) begin
            win <= win_ld;
        end else if (shift) begin
            win <= win_nxt;
        end
    end

endmodule

// File: rtl/sm3_cf_iter.sv
// Iterative SM3 compression function: V(i+1) = CF(V(i), B(i)) over a cf_start/cf_end level handshake.
// Latency: cf_end rises 65 edges after the load edge (33 with SM3_CF_UNROLL2_EN, two rounds/cycle).
// Backpressure: result held in DONE while cf_start stays high; cf_start low during RUN/FIN aborts.
module sm3_cf_iter
    import sm3_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         cf_start,
    input  logic [255:0] iv,
    input  logic [511:0] h_in,
    output logic [255:0] hashValue,
    output logic         cf_end
);

    state_t                state;
    state_t                state_nxt;
    regs_t                 regs;
    regs_t                 regs_nxt;
    logic [255:0]          v;
    logic [5:0]            j;
    logic                  load;
    logic                  shift;
    logic                  last;
    logic [RPC-1:0][31:0]  w_lo;
    logic [RPC-1:0][31:0]  w_hi;

    assign load  = (state == IDLE) && cf_start;
    assign shift = (state == RUN);
    assign last  = (j == 6'(ROUNDS - RPC));

    sm3_wexp u_wexp (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .blk   (h_in),
        .w_lo  (w_lo),
        .w_hi  (w_hi)
    );

    // Next-state logic; a dropped request in RUN or FIN abandons the block.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cf_start) state_nxt = RUN;
            RUN:     if (!cf_start) state_nxt = IDLE;
                     else if (last) state_nxt = FIN;
            FIN:     state_nxt = cf_start ? DONE : IDLE;
            DONE:    if (!cf_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round datapath: one round, or rounds j and j+1 chained when unrolled.
    always_comb begin
        regs_nxt = sm3_round(regs, j, w_lo[0], w_hi[0]);
`ifdef SM3_CF_UNROLL2_EN
        regs_nxt = sm3_round(regs_nxt, j + 6'd1, w_lo[1], w_hi[1]);
`endif
    end

    // Working registers, chaining value, round counter and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs      <= '0;
            v         <= '0;
            j         <= '0;
            hashValue <= '0;
            cf_end    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cf_start) begin
                        regs <= iv;
                        v    <= iv;
                        j    <= '0;
                    end
                end
                RUN: begin
                    regs <= regs_nxt;
                    j    <= j + 6'(RPC);
                end
                FIN: begin
                    if (cf_start) begin
                        hashValue <= regs ^ v;
                        cf_end    <= 1'b1;
                    end
                end
                DONE: begin
                    if (!cf_start) cf_end <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_cf_iter.sv
// Directed self-checking bench for sm3_cf_iter: known SM3 digests, handshake timing,
// input isolation, DONE hold, abort and mid-run reset.
// Build with SM3_CF_UNROLL2_EN defined to exercise the two-rounds-per-cycle variant.
module tb_sm3_cf_iter;

    localparam logic [255:0] STD_IV   = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [255:0] ABC_DIG  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] ABCD_DIG = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] ABCD_B1  = {16{32'h61626364}};
    localparam logic [511:0] ABCD_B2  = {32'h80000000, {14{32'h0}}, 32'h00000200};

`ifdef SM3_CF_UNROLL2_EN
    localparam int LAT      = 33;
    localparam int ABORT_AT = 10;
    localparam int RESET_AT = 20;
`else
    localparam int LAT      = 65;
    localparam int ABORT_AT = 20;
    localparam int RESET_AT = 40;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         cf_start;
    logic [255:0] iv;
    logic [511:0] h_in;
    logic [255:0] hashValue;
    logic         cf_end;

    int checks = 0;
    int errors = 0;
    int lat;

    sm3_cf_iter dut (
        .clk       (clk),
        .reset     (reset),
        .cf_start  (cf_start),
        .iv        (iv),
        .h_in      (h_in),
        .hashValue (hashValue),
        .cf_end    (cf_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a block and pass the load edge.
    task automatic start_block(input logic [255:0] v, input logic [511:0] b);
        iv       = v;
        h_in     = b;
        cf_start = 1'b1;
        tick;
    endtask

    // Count edges after the load edge until cf_end; optionally scramble inputs mid-run.
    task automatic wait_end(input bit perturb, output int n);
        n = 0;
        while (!cf_end && n < 200) begin
            tick;
            n++;
            if (perturb && n == 3) begin
                iv   = {8{$urandom}};
                h_in = {16{$urandom}};
            end
        end
    endtask

    task automatic release_start;
        cf_start = 1'b0;
        tick;
    endtask

    initial begin
        reset    = 1'b1;
        cf_start = 1'b0;
        iv       = '0;
        h_in     = '0;
        repeat (3) tick;
        check("rst_cf_end", 256'(cf_end), 256'(0));
        check("rst_hash", hashValue, '0);
        reset = 1'b0;
        tick;

        // "abc" single block, latency and DONE hold
        start_block(STD_IV, ABC_BLK);
        wait_end(1'b0, lat);
        check("abc_latency", 256'(lat), 256'(LAT));
        check("abc_digest", hashValue, ABC_DIG);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("hold_cf_end", 256'(cf_end), 256'(1));
            check("hold_hash", hashValue, ABC_DIG);
        end
        release_start;
        check("release_cf_end", 256'(cf_end), 256'(0));
        check("release_hash_kept", hashValue, ABC_DIG);

        // Two-block chain, block 2 chained from block 1's result
        start_block(STD_IV, ABCD_B1);
        wait_end(1'b0, lat);
        check("blk1_latency", 256'(lat), 256'(LAT));
        release_start;
        start_block(hashValue, ABCD_B2);
        wait_end(1'b0, lat);
        check("blk2_latency", 256'(lat), 256'(LAT));
        check("chain_digest", hashValue, ABCD_DIG);
        release_start;

        // Abort mid-run: result and cf_end untouched
        start_block(STD_IV, ABCD_B1);
        repeat (ABORT_AT) tick;
        cf_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("abort_cf_end", 256'(cf_end), 256'(0));
            check("abort_hash_kept", hashValue, ABCD_DIG);
        end

        // "abc" after abort, with inputs scrambled during RUN
        start_block(STD_IV, ABC_BLK);
        wait_end(1'b1, lat);
        check("iso_latency", 256'(lat), 256'(LAT));
        check("iso_digest", hashValue, ABC_DIG);
        release_start;

        // Reset mid-run, then a fresh run
        start_block(STD_IV, ABCD_B1);
        repeat (RESET_AT) tick;
        reset    = 1'b1;
        cf_start = 1'b0;
        tick;
        check("midrst_cf_end", 256'(cf_end), 256'(0));
        check("midrst_hash", hashValue, '0);
        reset = 1'b0;
        tick;
        start_block(STD_IV, ABC_BLK);
        wait_end(1'b0, lat);
        check("post_rst_latency", 256'(lat), 256'(LAT));
        check("post_rst_digest", hashValue, ABC_DIG);
        release_start;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
